// File: rtl/hs_pkg.sv
// Shared definitions for the hiscore upload reader: FSM state encoding,
// fill byte returned for reads outside the RAM window, default upload slot.
package hs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        READY   = 3'd2,
        FETCH   = 3'd3,
        RELEASE = 3'd4
    } hs_state_e;

    localparam int unsigned HS_IOCTL_AW     = 25;
    localparam logic [7:0]  HS_FILL         = 8'hFF;
    localparam logic [7:0]  HS_UPLOAD_INDEX = 8'd4;

endpackage

// File: rtl/hs_upload_reader.sv
// Serves HPS upload reads from a window of game RAM, pausing the CPU while
// the upload is active so the returned bytes are a consistent snapshot.
//
// Ports:
//   clk_sys, RESET_n           system clock, async active-low reset
//   ioctl_upload/index/rd/addr HPS upload request side (from hps_io)
//   ioctl_din, ioctl_wait      returned byte and host throttle
//   pause_req, paused          CPU pause handshake
//   ram_addr, ram_rd, ram_data shared hiscore RAM read port
//   busy                       high whenever the FSM is not IDLE
module hs_upload_reader
    import hs_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE         = ADDR_W'(16'h6000),
    parameter int unsigned       LEN          = 256,
    parameter int unsigned       RAM_LAT      = 1,
    parameter logic [7:0]        UPLOAD_INDEX = HS_UPLOAD_INDEX
) (
    input  logic                   clk_sys,
    input  logic                   RESET_n,
    input  logic                   ioctl_upload,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_rd,
    input  logic [HS_IOCTL_AW-1:0] ioctl_addr,
    output logic [7:0]             ioctl_din,
    output logic                   ioctl_wait,
    output logic                   pause_req,
    input  logic                   paused,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_rd,
    input  logic [7:0]             ram_data,
    output logic                   busy
);

    localparam logic [HS_IOCTL_AW-1:0] LEN_W = HS_IOCTL_AW'(LEN);

    hs_state_e                r_state;
    logic                     r_pend;
    logic [HS_IOCTL_AW-1:0]   r_pend_addr;
    logic                     r_wait;
    logic [7:0]               r_din;
    logic [ADDR_W-1:0]        r_ram_addr;
    logic                     r_ram_rd;
    logic                     r_pause;
    logic                     r_busy;
    logic [RAM_LAT-1:0]       r_lat;

    hs_state_e                w_nxt_state;
    logic                     w_nxt_pend;
    logic [HS_IOCTL_AW-1:0]   w_nxt_pend_addr;
    logic                     w_nxt_wait;
    logic [7:0]               w_nxt_din;
    logic [ADDR_W-1:0]        w_nxt_ram_addr;
    logic                     w_nxt_ram_rd;
    logic                     w_nxt_pause;

    logic                     w_active;
    logic                     w_rd_new;
    logic                     w_req;
    logic [HS_IOCTL_AW-1:0]   w_req_addr;
    logic                     w_req_in_win;
    logic                     w_cap;

    assign w_active = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
    // Strobes while already waiting are protocol violations and are dropped.
    assign w_rd_new = ioctl_rd & w_active & ~r_wait;
    assign w_req        = w_rd_new | r_pend;
    assign w_req_addr   = r_pend ? r_pend_addr : ioctl_addr;
    assign w_req_in_win = (w_req_addr < LEN_W);
    // Tap of the ram_rd delay line: RAM data is valid this cycle.
    assign w_cap = r_lat[RAM_LAT-1];

    // Next-state and next-output logic.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pend      = r_pend;
        w_nxt_pend_addr = r_pend_addr;
        w_nxt_wait      = r_wait;
        w_nxt_din       = r_din;
        w_nxt_ram_addr  = r_ram_addr;
        w_nxt_ram_rd    = 1'b0;
        w_nxt_pause     = r_pause;

        // A fresh strobe is held pending until it can be serviced.
        if (w_rd_new) begin
            w_nxt_pend      = 1'b1;
            w_nxt_pend_addr = ioctl_addr;
            w_nxt_wait      = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_active) begin
                    w_nxt_state = ARM;
                    w_nxt_pause = 1'b1;
                end
            end
            ARM: begin
                if (!w_active) begin
                    w_nxt_state = RELEASE;
                    w_nxt_pause = 1'b0;
                    w_nxt_pend  = 1'b0;
                    w_nxt_wait  = 1'b0;
                end else if (paused) begin
                    w_nxt_state = READY;
                end
            end
            READY: begin
                if (!w_active) begin
                    w_nxt_state = RELEASE;
                    w_nxt_pause = 1'b0;
                    w_nxt_pend  = 1'b0;
                    w_nxt_wait  = 1'b0;
                end else if (w_req && paused) begin
                    w_nxt_pend = 1'b0;
                    if (w_req_in_win) begin
                        w_nxt_ram_addr = BASE + w_req_addr[ADDR_W-1:0];
                        w_nxt_ram_rd   = 1'b1;
                        w_nxt_wait     = 1'b1;
                        w_nxt_state    = FETCH;
                    end else begin
                        w_nxt_din  = HS_FILL;
                        w_nxt_wait = 1'b0;
                    end
                end
            end
            FETCH: begin
                // The in-flight read always completes, even if the upload ended.
                if (w_cap) begin
                    w_nxt_din  = ram_data;
                    w_nxt_wait = 1'b0;
                    if (w_active) begin
                        w_nxt_state = READY;
                    end else begin
                        w_nxt_state = RELEASE;
                        w_nxt_pause = 1'b0;
                    end
                end
            end
            RELEASE: begin
                w_nxt_state = IDLE;
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_sys or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state     <= IDLE;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_wait      <= 1'b0;
            r_din       <= 8'h00;
            r_ram_addr  <= '0;
            r_ram_rd    <= 1'b0;
            r_pause     <= 1'b0;
            r_busy      <= 1'b0;
            r_lat       <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_pend      <= w_nxt_pend;
            r_pend_addr <= w_nxt_pend_addr;
            r_wait      <= w_nxt_wait;
            r_din       <= w_nxt_din;
            r_ram_addr  <= w_nxt_ram_addr;
            r_ram_rd    <= w_nxt_ram_rd;
            r_pause     <= w_nxt_pause;
            r_busy      <= (w_nxt_state != IDLE);
            r_lat       <= RAM_LAT'({r_lat, r_ram_rd});
        end
    end

    assign ioctl_din  = r_din;
    // Raised in the strobe cycle itself so the host cannot sample stale data.
    assign ioctl_wait = r_wait | (ioctl_rd & w_active);
    assign pause_req  = r_pause;
    assign ram_addr   = r_ram_addr;
    assign ram_rd     = r_ram_rd;
    assign busy       = r_busy;

endmodule

// File: tb/tb_hs_upload_reader.sv
// Randomized scoreboard bench for hs_upload_reader.
module tb_hs_upload_reader;

    localparam int TB_RAM_LAT = 3;
    localparam int TB_BASE    = 'h6000;
    localparam int TB_LEN     = 256;

    logic        clk_sys      = 1'b0;
    logic        RESET_n      = 1'b1;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index  = 8'd0;
    logic        ioctl_rd     = 1'b0;
    logic [24:0] ioctl_addr   = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        paused;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_data;
    logic        busy;

    logic        paused_r   = 1'b0;
    logic        pause_kill = 1'b0;
    int          pause_dly  = 3;
    int          pcnt       = 0;

    logic [7:0]  mem [65536];
    logic [7:0]  pipe [TB_RAM_LAT];

    logic [7:0]  exp_din [$];
    logic [15:0] exp_ram [$];
    logic [7:0]  last_din   = 8'h00;
    logic        prev_wait  = 1'b0;
    int          ram_rd_cnt = 0;
    int          vectors     = 0;
    int          miscompares = 0;

    hs_upload_reader #(.RAM_LAT(TB_RAM_LAT)) u_dut (
        .clk_sys      (clk_sys),
        .RESET_n      (RESET_n),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .paused       (paused),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_data     (ram_data),
        .busy         (busy)
    );

    always #25 clk_sys = ~clk_sys;

    // Pause block model: grants pause_dly cycles after the request.
    assign paused = paused_r & ~pause_kill;
    always @(posedge clk_sys) begin
        if (!pause_req) begin
            paused_r <= 1'b0;
            pcnt     <= 0;
        end else if (!paused_r) begin
            if (pcnt + 1 >= pause_dly) paused_r <= 1'b1;
            else pcnt <= pcnt + 1;
        end
    end

    // RAM with TB_RAM_LAT cycles of read latency; junk when not reading.
    assign ram_data = pipe[TB_RAM_LAT-1];
    always @(posedge clk_sys) begin
        pipe[0] <= ram_rd ? mem[ram_addr] : 8'($urandom);
        for (int k = 1; k < TB_RAM_LAT; k++) pipe[k] <= pipe[k-1];
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_byte(input logic [24:0] a);
        if (a < 25'(TB_LEN)) return mem[16'(TB_BASE + int'(a))];
        return 8'hFF;
    endfunction

    function automatic logic [24:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 25'($urandom_range(0, TB_LEN - 1));
            1:       return 25'(TB_LEN - 1 + int'($urandom_range(0, 1)));
            2:       return 25'($urandom);
            default: return 25'($urandom_range(0, 511));
        endcase
    endfunction

    // Monitor: checks every RAM access and every returned byte.
    always @(negedge clk_sys) begin
        if (!RESET_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (ram_rd) begin
                ram_rd_cnt <= ram_rd_cnt + 1;
                check(exp_ram.size() != 0, "unexpected_ram_rd", 32'(ram_addr), 0);
                if (exp_ram.size() != 0) begin
                    check(ram_addr == exp_ram[0], "ram_addr", 32'(ram_addr), 32'(exp_ram[0]));
                    void'(exp_ram.pop_front());
                end
                check(paused == 1'b1, "ram_rd_unpaused", 32'(paused), 1);
            end
            if (prev_wait && !ioctl_wait) begin
                check(exp_din.size() != 0, "unexpected_din", 32'(ioctl_din), 0);
                if (exp_din.size() != 0) begin
                    check(ioctl_din == exp_din[0], "din", 32'(ioctl_din), 32'(exp_din[0]));
                    last_din <= exp_din[0];
                    void'(exp_din.pop_front());
                end
            end
            prev_wait <= ioctl_wait;
        end
    end

    task automatic check_reset_vals();
        check(ioctl_din == 8'h00, "rst_din", 32'(ioctl_din), 0);
        check(ioctl_wait == 1'b0, "rst_wait", 32'(ioctl_wait), 0);
        check(pause_req == 1'b0, "rst_pause_req", 32'(pause_req), 0);
        check(ram_addr == 16'h0, "rst_ram_addr", 32'(ram_addr), 0);
        check(ram_rd == 1'b0, "rst_ram_rd", 32'(ram_rd), 0);
        check(busy == 1'b0, "rst_busy", 32'(busy), 0);
    endtask

    task automatic wait_paused();
        int n;
        n = 0;
        while (!paused && n < 200) begin @(negedge clk_sys); n++; end
        check(paused == 1'b1, "paused_timeout", 32'(paused), 1);
    endtask

    task automatic start_upload(input logic [7:0] idx, input bit wait_pause);
        @(posedge clk_sys); #1;
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        @(negedge clk_sys);
        check(pause_req == 1'b0, "pause_early", 32'(pause_req), 0);
        @(negedge clk_sys);
        check(pause_req == (idx == 8'd4), "pause_rise", 32'(pause_req), 32'(idx == 8'd4));
        if (wait_pause) wait_paused();
    endtask

    task automatic end_upload();
        @(posedge clk_sys); #1;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check(pause_req == 1'b1, "pause_hold", 32'(pause_req), 1);
        @(negedge clk_sys);
        check(pause_req == 1'b0, "pause_fall", 32'(pause_req), 0);
        check(busy == 1'b1, "busy_release", 32'(busy), 1);
        @(negedge clk_sys);
        check(busy == 1'b0, "busy_idle", 32'(busy), 0);
    endtask

    task automatic issue_read(input logic [24:0] a, input bit svc);
        int n;
        n = 0;
        while (ioctl_wait && n < 300) begin @(negedge clk_sys); n++; end
        check(ioctl_wait == 1'b0, "wait_low_timeout", 32'(ioctl_wait), 0);
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        if (svc) begin
            exp_din.push_back(model_byte(a));
            if (a < 25'(TB_LEN)) exp_ram.push_back(16'(TB_BASE + int'(a)));
        end
        @(negedge clk_sys);
        check(ioctl_wait == svc, "comb_wait", 32'(ioctl_wait), 32'(svc));
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
    endtask

    task automatic wait_done(input bit chk, input int exp_cyc);
        int cnt;
        cnt = 0;
        @(negedge clk_sys);
        while (ioctl_wait && cnt < 300) begin cnt++; @(negedge clk_sys); end
        check(ioctl_wait == 1'b0, "done_timeout", 32'(ioctl_wait), 0);
        if (chk) check(cnt == exp_cyc, "wait_cycles", 32'(cnt), 32'(exp_cyc));
    endtask

    task automatic do_read(input logic [24:0] a);
        issue_read(a, 1'b1);
        wait_done(1'b1, (a < 25'(TB_LEN)) ? 1 + TB_RAM_LAT : 0);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < TB_LEN; i++) mem[TB_BASE + i] = 8'(i) ^ 8'h5A;
        for (int k = 0; k < TB_RAM_LAT; k++) pipe[k] = 8'h00;

        #2 RESET_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        check_reset_vals();
        @(posedge clk_sys); #1 RESET_n = 1'b1;

        // Full sequential upload of the window.
        start_upload(8'd4, 1'b1);
        for (int i = 0; i < TB_LEN; i++) do_read(25'(i));
        end_upload();

        // Strobe arrives while still waiting for the pause grant.
        pause_dly = 20;
        start_upload(8'd4, 1'b0);
        n0 = ram_rd_cnt;
        issue_read(25'h10, 1'b1);
        wait_done(1'b0, 0);
        check(ram_rd_cnt == n0 + 1, "pending_ram_rd_count", 32'(ram_rd_cnt - n0), 1);
        pause_dly = 3;
        end_upload();

        // Window boundaries.
        start_upload(8'd4, 1'b1);
        n0 = ram_rd_cnt;
        do_read(25'd255);
        do_read(25'd256);
        do_read(25'h1FFFFFF);
        check(ram_rd_cnt == n0 + 1, "boundary_ram_rd_count", 32'(ram_rd_cnt - n0), 1);
        end_upload();

        // Wrong slot is ignored, then the right slot is served.
        start_upload(8'd0, 1'b0);
        repeat (8) @(negedge clk_sys);
        check(pause_req == 1'b0, "idx0_pause_req", 32'(pause_req), 0);
        check(busy == 1'b0, "idx0_busy", 32'(busy), 0);
        n0 = ram_rd_cnt;
        issue_read(25'h5, 1'b0);
        repeat (3) @(negedge clk_sys);
        check(ram_rd_cnt == n0, "idx0_ram_rd", 32'(ram_rd_cnt - n0), 0);
        check(ioctl_din == last_din, "idx0_din_hold", 32'(ioctl_din), 32'(last_din));
        @(posedge clk_sys); #1 ioctl_index = 8'd4;
        wait_paused();
        do_read(25'h5);

        // Second strobe while waiting is dropped.
        issue_read(25'h21, 1'b1);
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h22;
        @(posedge clk_sys); #1 ioctl_rd = 1'b0;
        wait_done(1'b0, 0);

        // Pause lost while READY: the strobe is held until it returns.
        pause_kill = 1'b1;
        issue_read(25'h20, 1'b1);
        repeat (8) @(negedge clk_sys);
        check(exp_ram.size() == 1, "held_no_fetch", 32'(exp_ram.size()), 1);
        check(ioctl_wait == 1'b1, "held_wait", 32'(ioctl_wait), 1);
        pause_kill = 1'b0;
        wait_done(1'b0, 0);
        end_upload();

        // Randomized reads.
        start_upload(8'd4, 1'b1);
        repeat (80) begin
            repeat ($urandom_range(0, 2)) @(posedge clk_sys);
            do_read(rand_addr());
        end
        end_upload();

        // Upload ends during an in-flight fetch.
        start_upload(8'd4, 1'b1);
        issue_read(25'h30, 1'b1);
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check(pause_req == 1'b1, "drop_pause_inflight", 32'(pause_req), 1);
        wait_done(1'b0, 0);
        check(pause_req == 1'b0, "drop_pause_after", 32'(pause_req), 0);
        check(busy == 1'b1, "drop_busy_release", 32'(busy), 1);
        @(negedge clk_sys);
        check(busy == 1'b0, "drop_busy_idle", 32'(busy), 0);
        check(pause_req == 1'b0, "drop_pause_idle", 32'(pause_req), 0);

        // Asynchronous reset mid-fetch, then a fresh upload.
        start_upload(8'd4, 1'b1);
        issue_read(25'h40, 1'b1);
        @(negedge clk_sys);
        @(posedge clk_sys); #3;
        RESET_n      = 1'b0;
        ioctl_upload = 1'b0;
        exp_din.delete();
        #1;
        check_reset_vals();
        repeat (3) @(posedge clk_sys);
        #1 RESET_n = 1'b1;
        start_upload(8'd4, 1'b1);
        do_read(25'h41);
        do_read(25'h0);
        end_upload();

        repeat (4) @(negedge clk_sys);
        check(exp_din.size() == 0, "din_queue_drained", 32'(exp_din.size()), 0);
        check(exp_ram.size() == 0, "ram_queue_drained", 32'(exp_ram.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
